// File: rtl/nn_rnn_weight_update.sv
// Weight-update block for one stochastic RNN node: integrates gradient bitstreams
// over a fixed window and applies one saturating gradient-descent step per window.
module nn_rnn_weight_update #(
  parameter int NB      = 16,
  parameter int NN      = 3,
  parameter int NR      = 3,
  parameter int LOGWIN  = 8,
  parameter int LRSHIFT = 4,
  parameter int WINIT   = 2**(NB-1)
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             EN,
  input  logic             CLR,
  input  logic             dsign,
  input  logic [NN-1:0]    dalpha,
  input  logic [NR-1:0]    dgamma,
  input  logic             dbeta,
  output logic [NN*NB-1:0] alpha,
  output logic [NR*NB-1:0] gamma,
  output logic [NB-1:0]    beta,
  output logic             upd_valid
);

  localparam int NW = NN + NR + 1;
  localparam int AW = LOGWIN + 2;
  localparam int WW = NB + LOGWIN + 2;
  localparam logic signed [WW-1:0] WZERO_S = {WW{1'b0}};
  localparam logic signed [WW-1:0] WMAX_S  = {{(WW-NB){1'b0}}, {NB{1'b1}}};
  localparam logic signed [AW-1:0] ONE_S   = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic {ACCUM = 1'b0, APPLY = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [LOGWIN-1:0]        wcnt_q, wcnt_d;
  logic signed [AW-1:0]     acc_q [NW];
  logic signed [AW-1:0]     acc_d [NW];
  logic [NB-1:0]            w_q [NW];
  logic [NB-1:0]            w_d [NW];
  logic                     upd_q, upd_d;
  logic [NW-1:0]            grad_s;

  // Weight order everywhere: alpha[0..NN-1], gamma[0..NR-1], beta.
  assign grad_s = {dbeta, dgamma, dalpha};

  function automatic logic [NB-1:0] apply_step(input logic [NB-1:0] w,
                                                input logic signed [AW-1:0] acc);
    logic signed [WW-1:0] w_s;
    logic signed [WW-1:0] acc_s;
    logic signed [WW-1:0] step_s;
    logic signed [WW-1:0] new_s;
    w_s    = $signed({{(WW-NB){1'b0}}, w});
    acc_s  = $signed({{(WW-AW){acc[AW-1]}}, acc});
    step_s = acc_s >>> LRSHIFT;
    new_s  = w_s - step_s;
    if (new_s < WZERO_S) begin
      return {NB{1'b0}};
    end else if (new_s > WMAX_S) begin
      return {NB{1'b1}};
    end else begin
      return new_s[NB-1:0];
    end
  endfunction

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    upd_d   = 1'b0;
    for (int i = 0; i < NW; i++) begin
      acc_d[i] = acc_q[i];
      w_d[i]   = w_q[i];
    end
    if (CLR) begin
      state_d = ACCUM;
      wcnt_d  = {LOGWIN{1'b0}};
      for (int i = 0; i < NW; i++) acc_d[i] = {AW{1'b0}};
    end else begin
      case (state_q)
        ACCUM: begin
          if (EN) begin
            for (int i = 0; i < NW; i++) begin
              if (grad_s[i]) begin
                acc_d[i] = dsign ? acc_q[i] - ONE_S : acc_q[i] + ONE_S;
              end else begin
                acc_d[i] = acc_q[i];
              end
            end
            // Counter wraps to zero naturally on the last sample of the window.
            wcnt_d  = wcnt_q + {{(LOGWIN-1){1'b0}}, 1'b1};
            state_d = (&wcnt_q) ? APPLY : ACCUM;
          end else begin
            state_d = ACCUM;
          end
        end
        APPLY: begin
          for (int i = 0; i < NW; i++) begin
            w_d[i]   = apply_step(w_q[i], acc_q[i]);
            acc_d[i] = {AW{1'b0}};
          end
          upd_d   = 1'b1;
          state_d = ACCUM;
        end
        default: begin
          state_d = ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      state_q <= ACCUM;
      wcnt_q  <= {LOGWIN{1'b0}};
      upd_q   <= 1'b0;
      for (int i = 0; i < NW; i++) begin
        acc_q[i] <= {AW{1'b0}};
        w_q[i]   <= NB'(WINIT);
      end
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      upd_q   <= upd_d;
      for (int i = 0; i < NW; i++) begin
        acc_q[i] <= acc_d[i];
        w_q[i]   <= w_d[i];
      end
    end
  end

  for (genvar n = 0; n < NN; n++) begin : g_alpha
    assign alpha[n*NB +: NB] = w_q[n];
  end
  for (genvar n = 0; n < NR; n++) begin : g_gamma
    assign gamma[n*NB +: NB] = w_q[NN+n];
  end
  assign beta      = w_q[NW-1];
  assign upd_valid = upd_q;

endmodule

// File: tb/tb_nn_rnn_weight_update.sv
// Scoreboard bench: two instances (learning-rate shift 2 and 0) share stimulus and
// are compared against a window-level arithmetic model of the weight update.
module tb_nn_rnn_weight_update;
  localparam int NB = 8;
  localparam int NW = 5;
  localparam int WINLEN = 16;

  typedef struct packed {
    logic [31:0]          cyc;
    logic [2*NW-1:0][7:0] w;
  } exp_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] d;
    logic [31:0] i;
    logic [31:0] v;
  } dir_t;

  logic        CLK, INIT, EN, CLR, dsign, dbeta;
  logic [1:0]  dalpha, dgamma;
  logic [15:0] alpha_o [2];
  logic [15:0] gamma_o [2];
  logic [7:0]  beta_o [2];
  logic        upd_o [2];

  exp_t                 q [$];
  dir_t                 dq [$];
  logic [2*NW-1:0][7:0] shadow;
  int                   acc [NW];
  int                   wm [2*NW];
  int                   cnt;
  bit                   pending;
  bit                   done;
  int                   cyc = 0;
  int                   total = 0;
  int                   bad = 0;

  nn_rnn_weight_update #(.NB(NB), .NN(2), .NR(2), .LOGWIN(4), .LRSHIFT(2), .WINIT(128)) u_dut0 (
    .CLK(CLK), .INIT(INIT), .EN(EN), .CLR(CLR), .dsign(dsign), .dalpha(dalpha),
    .dgamma(dgamma), .dbeta(dbeta), .alpha(alpha_o[0]), .gamma(gamma_o[0]),
    .beta(beta_o[0]), .upd_valid(upd_o[0]));

  nn_rnn_weight_update #(.NB(NB), .NN(2), .NR(2), .LOGWIN(4), .LRSHIFT(0), .WINIT(128)) u_dut1 (
    .CLK(CLK), .INIT(INIT), .EN(EN), .CLR(CLR), .dsign(dsign), .dalpha(dalpha),
    .dgamma(dgamma), .dbeta(dbeta), .alpha(alpha_o[1]), .gamma(gamma_o[1]),
    .beta(beta_o[1]), .upd_valid(upd_o[1]));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int get_w(int d, int i);
    if (i < 2) return int'(alpha_o[d][i*8 +: 8]);
    else if (i < 4) return int'(gamma_o[d][(i-2)*8 +: 8]);
    else return int'(beta_o[d]);
  endfunction

  task automatic chk(string nm, int act, int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp_v);
    end
  endtask

  // Reference: per-weight signed sums over a window; update = floor(sum / 2^shift).
  task automatic model_edge();
    logic [4:0] bits;
    exp_t       e;
    int         st, nw;
    bits = {dbeta, dgamma, dalpha};
    if (CLR) begin
      foreach (acc[i]) acc[i] = 0;
      cnt = 0;
      pending = 0;
    end else if (pending) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < NW; i++) begin
          st = int'($floor(real'(acc[i]) / real'(2 ** ((d == 0) ? 2 : 0))));
          nw = wm[d*NW+i] - st;
          if (nw < 0) nw = 0;
          if (nw > 255) nw = 255;
          wm[d*NW+i] = nw;
          e.w[d*NW+i] = 8'(nw);
        end
      end
      e.cyc = 32'(cyc + 1);
      q.push_back(e);
      foreach (acc[i]) acc[i] = 0;
      pending = 0;
    end else if (EN) begin
      for (int i = 0; i < NW; i++) if (bits[i]) acc[i] += dsign ? -1 : 1;
      cnt++;
      if (cnt == WINLEN) begin
        cnt = 0;
        pending = 1;
      end
    end
  endtask

  task automatic step(input logic en, input logic clr, input logic sg,
                      input logic [1:0] a, input logic [1:0] g, input logic b);
    @(negedge CLK);
    EN = en; CLR = clr; dsign = sg; dalpha = a; dgamma = g; dbeta = b;
    model_edge();
  endtask

  task automatic samples(input int n, input logic sg, input logic [1:0] a,
                         input logic [1:0] g, input logic b);
    repeat (n) step(1'b1, 1'b0, sg, a, g, b);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic dir(input int d, input int i, input int v);
    dir_t e;
    e.cyc = 32'(cyc + 1); e.d = 32'(d); e.i = 32'(i); e.v = 32'(v);
    dq.push_back(e);
  endtask

  task automatic model_reset();
    foreach (acc[i]) acc[i] = 0;
    foreach (wm[i]) wm[i] = 128;
    cnt = 0;
    pending = 0;
  endtask

  // Monitor: checks reset values on INIT, and every cycle upd_valid and all weights.
  initial begin
    bit   exp_upd;
    dir_t de;
    foreach (shadow[i]) shadow[i] = 8'd128;
    forever begin
      @(negedge CLK or posedge INIT);
      if (INIT) begin
        #1;
        q.delete();
        foreach (shadow[i]) shadow[i] = 8'd128;
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("reset_upd_valid dut%0d", d), int'(upd_o[d]), 0);
          for (int i = 0; i < NW; i++) chk($sformatf("reset_weight dut%0d w%0d", d, i), get_w(d, i), 128);
        end
      end else begin
        exp_upd = (q.size() > 0) && (int'(q[0].cyc) == cyc);
        for (int d = 0; d < 2; d++) chk($sformatf("upd_valid dut%0d", d), int'(upd_o[d]), int'(exp_upd));
        if (exp_upd) shadow = q.pop_front().w;
        for (int d = 0; d < 2; d++)
          for (int i = 0; i < NW; i++)
            chk($sformatf("weight dut%0d w%0d", d, i), get_w(d, i), int'(shadow[d*NW+i]));
        while (dq.size() > 0 && int'(dq[0].cyc) <= cyc) begin
          de = dq.pop_front();
          chk($sformatf("directed dut%0d w%0d", de.d, de.i), get_w(int'(de.d), int'(de.i)), int'(de.v));
        end
        if (done) begin
          chk("scoreboard_drain", q.size(), 0);
          chk("directed_drain", dq.size(), 0);
          $display("test done: total=%0d bad=%0d", total, bad);
          $finish;
        end
      end
    end
  end

  // Stimulus
  initial begin
    INIT = 1'b1; EN = 1'b0; CLR = 1'b0; dsign = 1'b0;
    dalpha = 2'b00; dgamma = 2'b00; dbeta = 1'b0; done = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    #1 INIT = 1'b0;

    // Single stream on alpha0.
    samples(16, 1'b0, 2'b01, 2'b00, 1'b0);
    idle(1);
    dir(0, 0, 124); dir(1, 0, 112); dir(0, 1, 128);
    idle(2);

    // Asynchronous reset mid-window, then a window of zeros.
    samples(9, 1'b0, 2'b01, 2'b00, 1'b0);
    @(negedge CLK);
    EN = 1'b0; dalpha = 2'b00;
    #1 INIT = 1'b1;
    model_reset();
    #3 INIT = 1'b0;
    samples(16, 1'b0, 2'b00, 2'b00, 1'b0);
    idle(1);
    dir(0, 0, 128); dir(1, 0, 128);
    idle(2);

    // Mixed sign on beta, then rounding toward -inf.
    samples(10, 1'b0, 2'b00, 2'b00, 1'b1);
    samples(6, 1'b1, 2'b00, 2'b00, 1'b1);
    idle(1);
    dir(0, 4, 127); dir(1, 4, 124);
    idle(2);
    samples(3, 1'b1, 2'b00, 2'b00, 1'b1);
    samples(13, 1'b0, 2'b00, 2'b00, 1'b0);
    idle(1);
    dir(0, 4, 128); dir(1, 4, 127);
    idle(2);

    // Pause mid-window with inputs toggling while EN is low.
    samples(8, 1'b0, 2'b01, 2'b00, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    samples(8, 1'b0, 2'b01, 2'b00, 1'b0);
    idle(1);
    dir(0, 0, 124); dir(1, 0, 112);
    idle(2);

    // CLR mid-window, then CLR during the apply cycle.
    samples(12, 1'b0, 2'b01, 2'b00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
    samples(16, 1'b0, 2'b00, 2'b00, 1'b0);
    idle(1);
    samples(16, 1'b0, 2'b01, 2'b00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0);
    idle(3);
    dir(0, 0, 124); dir(1, 0, 112);
    idle(2);

    // Saturation at both rails; gradient held through apply cycles too.
    repeat (9) repeat (WINLEN + 1) step(1'b1, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0);
    idle(1);
    dir(0, 3, 164); dir(1, 3, 255);
    idle(2);
    repeat (9) repeat (WINLEN + 1) step(1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0);
    idle(1);
    dir(0, 1, 92); dir(1, 1, 0);
    idle(2);

    // Random traffic with occasional window aborts.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    idle(20);
    done = 1'b1;
    repeat (5) @(negedge CLK);
    $display("FAIL monitor_timeout: monitor did not finish");
    $fatal(1);
  end
endmodule

// File: doc/nn_rnn_weight_update.md
Name: nn_rnn_weight_update

Overview:
- Consumes the stochastic gradient bitstreams from the RNN backprop node: dalpha per previous-layer input, dgamma per recurrent input, dbeta for bias.
- Integrates each gradient stream over a fixed window of enabled cycles, scales the result by a learning-rate shift, and applies one saturating gradient-descent step to the node's stored alpha/gamma/beta weights.
- Holds those weights and drives them back to the forward node and the stochastic number generators.

Parameters:
- NB, 16, weight bit precision (unsigned weight registers)
- NN, 3, number of nodes in previous layer (alpha weights)
- NR, 3, number of nodes in current layer (gamma weights)
- LOGWIN, 8, log2 of accumulation window length; WINLEN = 2^LOGWIN enabled cycles
- LRSHIFT, 4, learning-rate right-shift applied to the accumulated gradient (0 ≤ LRSHIFT ≤ LOGWIN)
- WINIT, 2^(NB-1), reset value of every weight (mid-scale)

Ports:
- CLK  input  1  clock
- INIT  input  1  reset, asynchronous, active-high
- EN  input  1  sample enable; gradient bits are accumulated only when high
- CLR  input  1  synchronous window abort: clears accumulators and window counter, weights untouched
- dsign  input  1  sign of delta for this node: 0 = positive gradient, 1 = negative gradient
- dalpha  input  NN  alpha gradient bitstreams
- dgamma  input  NR  gamma gradient bitstreams
- dbeta  input  1  beta gradient bitstream
- alpha  output  NN*NB  alpha weights; weight n at [n*NB +: NB]
- gamma  output  NR*NB  gamma weights; same packing
- beta  output  NB  bias weight
- upd_valid  output  1  one-cycle pulse when new weights are visible

Behaviour:
- Reset (INIT high, asynchronous):
  - every alpha/gamma/beta register = WINIT; all accumulators = 0; wcnt = 0
  - state = ACCUM; upd_valid = 0
- Accumulators:
  - one per weight (NN+NR+1 total), signed, LOGWIN+2 bits
- State ACCUM:
  - On each edge with EN=1, every accumulator adds +1 if its bit=1 and dsign=0, adds -1 if its bit=1 and dsign=1, and is unchanged if its bit=0. wcnt increments.
  - When EN=1 and wcnt = WINLEN-1, that final sample is accumulated, wcnt wraps to 0, and the next state is APPLY.
  - EN=0: accumulators, wcnt and state hold (window pauses, does not restart).
- State APPLY (exactly one cycle; EN and gradient inputs ignored, bits this cycle are dropped):
  - step = acc >>> LRSHIFT (arithmetic shift, rounds toward −inf)
  - w_new = w − step, computed in NB+LOGWIN+2 signed width
  - saturate: w_new < 0 → 0; w_new > 2^NB−1 → 2^NB−1
  - On the APPLY edge, all weights load w_new simultaneously, all accumulators clear to 0, upd_valid is set to 1, and the next state is ACCUM.
- upd_valid:
  - high for exactly the one cycle following the APPLY edge, then low
- Latency and window period:
  - The first sample is taken at edge 1 of the window.
  - The weight change is visible after edge WINLEN+1 (counting only EN-high cycles in ACCUM).
  - Minimum window period is WINLEN+1 cycles.
- CLR (synchronous, priority over EN):
  - accumulators = 0, wcnt = 0, state = ACCUM, upd_valid = 0; weights unchanged
  - CLR during APPLY cancels the update
- Outputs are direct register outputs with no combinational path from inputs.

Test Plan:
(Config for all: NB=8, NN=2, NR=2, LOGWIN=4 (WINLEN=16), LRSHIFT=2, WINIT=128.)
- Reset: assert INIT mid-window after 9 samples of dalpha[0]=1 → all weights 128 immediately (async), upd_valid=0; a following full window of zeros leaves all weights 128 and pulses upd_valid once.
- Single stream: EN=1, dsign=0, dalpha[0]=1 for 16 cycles, other bits 0 → at APPLY edge (edge 17) alpha0=124, others 128; upd_valid high exactly one cycle.
- Mixed sign and rounding, two windows:
  - Window 1: dbeta=1 for 10 samples with dsign=0 and 6 samples with dsign=1 → beta=127.
  - Window 2: dbeta=1 for 3 samples with dsign=1, remaining samples 0 → acc=−3, step=−1, beta=128.
- Saturation: dgamma[1]=1 with dsign=1 every cycle for 8 windows → gamma1 climbs 132, 136, …, 160. Rerun with LRSHIFT=0: 144, 160, …, 240, then 255, and it stays 255 on the 9th window. Likewise dalpha[1]=1 with dsign=0 and LRSHIFT=0 → gamma/alpha weight reaches 0 and stays 0.
- Pause: 8 samples, EN low for 5 cycles (toggle dalpha during pause), 8 more samples with dalpha[0]=1 throughout enabled cycles → alpha0=124, upd_valid 21 cycles after the first sample edge + 1.
- CLR: pulse CLR after 12 samples of dalpha[0]=1, then a full window of zeros → alpha0 stays 128; CLR asserted during APPLY → no weight change, no upd_valid.
